// File: rtl/buf_arb_pkg.sv
// Shared definitions for the buf_manager request arbiter.
package buf_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StResp = 2'd2
    } state_e;

    // buf_manager returns all-ones on an alloc when no buffer is free; sliced to DATA_WIDTH.
    localparam logic [63:0] NO_BUF = '1;

    // buf_manager exposes a single register at address 0; sliced to ADDR_WIDTH.
    localparam logic [63:0] BUF_MGR_ADDR = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 with wrap.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid
);

    logic [IDXW-1:0] idx;

    // First requester after last_grant wins; last_grant itself has lowest priority.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = IDXW'((32'(last_grant) + i) % NREQ);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/buf_alloc_arbiter.sv
// Shares buf_manager's Wishbone slave port between NREQ alloc/free requesters.
module buf_alloc_arbiter
    import buf_arb_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NBUFS      = 13,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_free,
    input  logic [NREQ*DATA_WIDTH-1:0] req_id,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_id,
    output logic                       rsp_fail,
    output logic                       busy,
    output logic [ADDR_WIDTH-1:0]      wbm_address,
    output logic [DATA_WIDTH-1:0]      wbm_writedata,
    input  logic [DATA_WIDTH-1:0]      wbm_readdata,
    output logic                       wbm_strobe,
    output logic                       wbm_cycle,
    output logic                       wbm_write,
    input  logic                       wbm_ack
);

    localparam int unsigned IDXW = $clog2(NREQ);
    localparam int unsigned TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]         TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] NBUFS_ID   = DATA_WIDTH'(NBUFS);
    localparam logic [DATA_WIDTH-1:0] NO_BUF_ID  = NO_BUF[DATA_WIDTH-1:0];

    state_e                state_q, state_d;
    logic [IDXW-1:0]       last_grant_q, last_grant_d;
    logic [IDXW-1:0]       winner_q, winner_d;
    logic                  free_q, free_d;
    logic [DATA_WIDTH-1:0] id_q, id_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [NREQ-1:0]       req_ready_q, req_ready_d;
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_id_q, rsp_id_d;
    logic                  rsp_fail_q, rsp_fail_d;
    logic                  busy_q, busy_d;

    logic [NREQ-1:0]       grant;
    logic [IDXW-1:0]       grant_idx;
    logic                  grant_valid;
    logic [DATA_WIDTH-1:0] sel_id;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_arbiter (
        .req         (req_valid),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign sel_id = req_id[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        free_d       = free_q;
        id_d         = id_q;
        timer_d      = timer_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_id_d     = rsp_id_q;
        rsp_fail_d   = rsp_fail_q;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    winner_d     = grant_idx;
                    last_grant_d = grant_idx;
                    req_ready_d  = grant;
                    free_d       = req_free[grant_idx];
                    id_d         = req_free[grant_idx] ? sel_id : '0;
                    timer_d      = '0;
                    if (req_free[grant_idx] && (sel_id >= NBUFS_ID)) begin
                        // Out-of-range free is rejected locally without touching the bus.
                        state_d               = StResp;
                        rsp_valid_d[grant_idx] = 1'b1;
                        rsp_id_d              = sel_id;
                        rsp_fail_d            = 1'b1;
                    end else begin
                        state_d = StBus;
                    end
                end
            end
            StBus: begin
                if (!cyc_q) begin
                    // Launch cycle: bus goes active one edge after the accept pulse.
                    cyc_d = 1'b1;
                    we_d  = free_q;
                end else if (wbm_ack) begin
                    // Ack wins even in the cycle the timer expires.
                    cyc_d                 = 1'b0;
                    we_d                  = 1'b0;
                    state_d               = StResp;
                    rsp_valid_d[winner_q] = 1'b1;
                    rsp_id_d              = free_q ? id_q : wbm_readdata;
                    rsp_fail_d            = !free_q && (wbm_readdata == NO_BUF_ID);
                end else if (timer_q == TIMER_LAST) begin
                    cyc_d                 = 1'b0;
                    we_d                  = 1'b0;
                    state_d               = StResp;
                    rsp_valid_d[winner_q] = 1'b1;
                    rsp_id_d              = '0;
                    rsp_fail_d            = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset clears the bus immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= IDXW'(NREQ - 1);
            winner_q     <= '0;
            free_q       <= 1'b0;
            id_q         <= '0;
            timer_q      <= '0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_id_q     <= '0;
            rsp_fail_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            free_q       <= free_d;
            id_q         <= id_d;
            timer_q      <= timer_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_fail_q   <= rsp_fail_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_fail      = rsp_fail_q;
    assign busy          = busy_q;
    assign wbm_address   = BUF_MGR_ADDR[ADDR_WIDTH-1:0];
    assign wbm_writedata = id_q;
    assign wbm_cycle     = cyc_q;
    assign wbm_strobe    = cyc_q;
    assign wbm_write     = we_q;

endmodule

// File: tb/tb_buf_alloc_arbiter.sv
// Scoreboard bench for buf_alloc_arbiter with a small buf_manager bus model.
module tb_buf_alloc_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 16;
    localparam int unsigned NBUFS = 13;

    logic clk = 1'b0;
    logic reset;
    logic [NREQ-1:0]    req_valid, req_free, req_ready, rsp_valid;
    logic [NREQ*DW-1:0] req_id;
    logic [DW-1:0]      rsp_id, wbm_writedata;
    logic [DW-1:0]      wbm_readdata = '1;
    logic               rsp_fail, busy, wbm_strobe, wbm_cycle, wbm_write;
    logic               wbm_ack = 1'b0;
    logic [AW-1:0]      wbm_address;

    typedef struct packed {
        logic [1:0]    req;
        logic [DW-1:0] id;
        logic          fail;
    } exp_t;

    exp_t        rsp_q[$];
    int unsigned grant_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cnt[NREQ];
    int unsigned cyc_hi = 0;

    // Bus model state
    logic             ack_enable;
    logic             pool_load;
    logic [NBUFS-1:0] pool_init;
    logic [NBUFS-1:0] pool = '1;
    logic             ack_we = 1'b0;
    logic [DW-1:0]    ack_wdata = '0;
    logic [AW-1:0]    ack_addr = '0;
    int unsigned      bus_txns = 0;

    buf_alloc_arbiter u_dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_free      (req_free),
        .req_id        (req_id),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_fail      (rsp_fail),
        .busy          (busy),
        .wbm_address   (wbm_address),
        .wbm_writedata (wbm_writedata),
        .wbm_readdata  (wbm_readdata),
        .wbm_strobe    (wbm_strobe),
        .wbm_cycle     (wbm_cycle),
        .wbm_write     (wbm_write),
        .wbm_ack       (wbm_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [DW-1:0] act);
        checks++;
        errors++;
        $display("FAIL unexpected_%s: actual 0x%0h required none", name, act);
    endtask

    function automatic logic [NREQ-1:0] onehot(input int unsigned i);
        return NREQ'(1) << i;
    endfunction

    function automatic logic [DW-1:0] first_free(input logic [NBUFS-1:0] p);
        for (int i = 0; i < NBUFS; i++) begin
            if (p[i]) return DW'(i);
        end
        return '1;
    endfunction

    task automatic expect_op(input int unsigned r, input logic [DW-1:0] id, input logic fail);
        exp_t e;
        e.req  = r[1:0];
        e.id   = id;
        e.fail = fail;
        grant_q.push_back(r);
        rsp_q.push_back(e);
    endtask

    // buf_manager model: acks every active bus cycle on its first cycle, lowest free id first.
    always @(negedge clk) begin
        if (pool_load) begin
            pool = pool_init;
        end else if (wbm_ack) begin
            bus_txns++;
            if (ack_we) begin
                if (ack_wdata < NBUFS) pool[ack_wdata[3:0]] = 1'b1;
            end else if (wbm_readdata != '1) begin
                pool[wbm_readdata[3:0]] = 1'b0;
            end
        end
        wbm_readdata = first_free(pool);
        wbm_ack      = ack_enable && wbm_cycle && wbm_strobe;
        if (wbm_ack) begin
            ack_we    = wbm_write;
            ack_wdata = wbm_writedata;
            ack_addr  = wbm_address;
        end
    end

    // Monitor: compare every accept and completion pulse against the scoreboard.
    always @(negedge clk) begin
        exp_t        e;
        int unsigned g;
        if (wbm_cycle) cyc_hi++;
        if (req_ready != '0) begin
            if (grant_q.size() == 0) begin
                unexpected("grant", DW'(req_ready));
            end else begin
                g = grant_q.pop_front();
                check("grant", DW'(req_ready), DW'(onehot(g)));
            end
        end
        if (rsp_valid != '0) begin
            if (rsp_q.size() == 0) begin
                unexpected("rsp_valid", DW'(rsp_valid));
            end else begin
                e = rsp_q.pop_front();
                check("rsp_valid", DW'(rsp_valid), DW'(onehot(e.req)));
                check("rsp_id", rsp_id, e.id);
                check("rsp_fail", DW'(rsp_fail), DW'(e.fail));
            end
        end
    end

    task automatic load_pool(input logic [NBUFS-1:0] v);
        pool_init = v;
        pool_load = 1'b1;
        repeat (2) @(negedge clk);
        pool_load = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
    endtask

    // Hold each requester's req_valid until it has been accepted cnt[i] times.
    task automatic run_reqs(input int budget);
        int n = 0;
        for (int i = 0; i < NREQ; i++) req_valid[i] = (cnt[i] > 0);
        while (req_valid != '0 && n < budget) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    cnt[i]--;
                    req_valid[i] = (cnt[i] > 0);
                end
            end
        end
        check("requests_accepted", DW'(req_valid), '0);
        req_valid = '0;
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && rsp_q.size() != 0; n++) @(negedge clk);
        check("drain_pending", DW'(rsp_q.size()), '0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int unsigned t0;
        logic        got;
        reset      = 1'b0;
        req_valid  = '0;
        req_free   = '0;
        req_id     = '0;
        ack_enable = 1'b1;
        pool_load  = 1'b1;
        pool_init  = '1;
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;

        // Reset: all outputs low throughout, idle after release.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_ctrl", DW'({req_ready, rsp_valid, rsp_fail, busy, wbm_cycle,
                                     wbm_strobe, wbm_write}), '0);
            check("reset_data", rsp_id | wbm_writedata | DW'(wbm_address), '0);
        end
        reset     = 1'b1;
        pool_load = 1'b0;
        @(negedge clk);
        check("busy_after_reset", DW'(busy), '0);

        // Single alloc from requester 1, ids 0..4 already taken in the model.
        load_pool(13'h1FE0);
        expect_op(1, 5, 1'b0);
        req_free  = '0;
        req_valid = 4'b0010;
        got       = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = req_ready[1];
        end
        req_valid = '0;
        check("grant_wait", DW'(got), 1);
        @(negedge clk);
        check("lat_cycle", DW'(wbm_cycle), 1);
        check("lat_strobe", DW'(wbm_strobe), 1);
        check("lat_write", DW'(wbm_write), 0);
        check("lat_address", DW'(wbm_address), 0);
        @(negedge clk);
        check("lat_rsp_valid", DW'(rsp_valid), DW'(4'b0010));
        drain(30);

        // All four requesters from reset: grants 0,1,2,3,0,1.
        do_reset(3);
        load_pool('1);
        cnt = '{2, 2, 1, 1};
        expect_op(0, 0, 1'b0);
        expect_op(1, 1, 1'b0);
        expect_op(2, 2, 1'b0);
        expect_op(3, 3, 1'b0);
        expect_op(0, 4, 1'b0);
        expect_op(1, 5, 1'b0);
        run_reqs(100);
        drain(30);

        // Free of an out-of-range id is rejected without a bus cycle.
        c0 = cyc_hi;
        req_free            = 4'b0100;
        req_id[2*DW +: DW]  = 13;
        cnt                 = '{0, 0, 1, 0};
        expect_op(2, 13, 1'b1);
        run_reqs(20);
        drain(10);
        check("free_invalid_no_bus", DW'(cyc_hi - c0), '0);

        // Free of the last valid id goes to the bus as a write.
        t0                 = bus_txns;
        req_id[2*DW +: DW] = 12;
        cnt                = '{0, 0, 1, 0};
        expect_op(2, 12, 1'b0);
        run_reqs(20);
        drain(30);
        check("free_bus_txns", DW'(bus_txns - t0), 1);
        check("free_we", DW'(ack_we), 1);
        check("free_wdata", ack_wdata, 12);
        check("free_addr", DW'(ack_addr), 0);
        req_free = '0;

        // Exhaust the 13 buffers, then one more alloc fails.
        load_pool('1);
        cnt = '{14, 0, 0, 0};
        for (int i = 0; i < 13; i++) expect_op(0, DW'(i), 1'b0);
        expect_op(0, '1, 1'b1);
        run_reqs(200);
        drain(30);

        // No ack: bus stays up for exactly 16 cycles, then times out.
        ack_enable = 1'b0;
        c0         = cyc_hi;
        cnt        = '{0, 0, 0, 1};
        expect_op(3, 0, 1'b1);
        run_reqs(20);
        drain(40);
        check("timeout_cyc_cycles", DW'(cyc_hi - c0), 16);

        // Reset during BUS: bus drops asynchronously, no response follows.
        grant_q.push_back(0);
        cnt = '{1, 0, 0, 0};
        run_reqs(20);
        for (int n = 0; n < 5 && !wbm_cycle; n++) @(negedge clk);
        check("abort_bus_active", DW'(wbm_cycle), 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_cycle", DW'(wbm_cycle), 0);
        check("abort_strobe", DW'(wbm_strobe), 0);
        check("abort_busy", DW'(busy), 0);
        repeat (3) @(negedge clk);
        reset      = 1'b1;
        ack_enable = 1'b1;
        repeat (40) @(negedge clk);

        check("rsp_queue_empty", DW'(rsp_q.size()), '0);
        check("grant_queue_empty", DW'(grant_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buf_alloc_arbiter.md
Name: buf_alloc_arbiter

Overview:
Shares the single Wishbone slave port of buf_manager between NREQ requesters, each of which can issue buffer-alloc or buffer-free requests. Requests are granted round-robin and executed as one Wishbone classic cycle at a time. The result (allocated buffer id or failure) is returned to the granted requester. It sits between the packet-handling clients and buf_manager.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDR_WIDTH, 16, Wishbone address width
DATA_WIDTH, 32, Wishbone data width, also the buffer-id width
NBUFS, 13, buffer count in buf_manager; valid ids are 0..NBUFS-1
TIMEOUT, 16, maximum cycles to wait for wbm_ack (at least 2)

Ports:
clk  in  1  clock, all logic on its rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request pending; held until req_ready
req_free  in  NREQ  per-requester operation: 1 = free, 0 = alloc
req_id  in  NREQ*DATA_WIDTH  id to free; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NREQ  one-cycle accept pulse to the granted requester
rsp_valid  out  NREQ  one-cycle completion pulse to the granted requester
rsp_id  out  DATA_WIDTH  allocated id (alloc), echoed id (free)
rsp_fail  out  1  operation failed; qualified by rsp_valid
busy  out  1  FSM not in IDLE
wbm_address  out  ADDR_WIDTH  always 0
wbm_writedata  out  DATA_WIDTH  id being freed
wbm_readdata  in  DATA_WIDTH  allocated id, or all-ones when no buffer is free
wbm_strobe  out  1  Wishbone strobe
wbm_cycle  out  1  Wishbone cycle
wbm_write  out  1  1 = free (write), 0 = alloc (read)
wbm_ack  in  1  Wishbone acknowledge

Behaviour:
- All outputs are registered. While reset is low, every output is 0, the FSM is in IDLE and last_grant = NREQ-1.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - If any req_valid is high, pick the winner round-robin, searching from last_grant+1 with wrap.
  - Latch the winner's op and id, pulse req_ready[winner] for one cycle, and set last_grant = winner.
  - Free with id >= NBUFS: go to RESP with fail=1 and issue no bus cycle.
  - Otherwise drive wbm_cycle, wbm_strobe, wbm_write, wbm_writedata and wbm_address from the next edge, and go to BUS.
- BUS:
  - Bus signals are held stable and the timer increments each cycle.
  - On wbm_ack: drop cycle/strobe on the next edge, capture wbm_readdata on alloc, and go to RESP.
  - Alloc fails if the captured readdata is all-ones.
  - If the timer reaches TIMEOUT with no ack: drop cycle/strobe, set fail=1 and rsp_id=0, then go to RESP.
  - An ack in the same cycle the timer expires counts as success.
- RESP: pulse rsp_valid[winner] for one cycle with rsp_id and rsp_fail valid in that cycle, then return to IDLE.
- Minimum latency with ack on the first BUS cycle:
  - req_ready at cycle T.
  - Bus active at T+1.
  - ack at T+1.
  - rsp_valid at T+2.
  - Next grant no earlier than T+3.
- wbm_ack outside BUS is ignored.
- req_valid dropping before req_ready is tolerated; that request is simply not selected.
- Reset asserted mid-operation: cycle/strobe clear immediately (asynchronously) and no rsp_valid is issued for the aborted request.

Decomposition:
- Package buf_arb_pkg holds: state encoding (IDLE/BUS/RESP), the all-ones NO_BUF constant, and the fixed buf_manager register address 0.
- One sub-module, rr_arbiter, takes NREQ request bits and last_grant and outputs a one-hot grant plus grant index. It is purely combinational and parameterised on NREQ.

Test Plan:
- Reset held low for 10 cycles, then released -> every output is 0 throughout; busy=0 after release.
- Requester 1 allocs and the model acks on the first BUS cycle with readdata=5 -> req_ready[1] at T, wbm_cycle=wbm_strobe=1 and wbm_write=0 at T+1, rsp_valid[1] at T+2 with rsp_id=5 and rsp_fail=0.
- All 4 requesters alloc continuously from reset -> grant order 0,1,2,3,0,1; each request gets exactly one rsp_valid.
- Requester 2 frees id 13 -> rsp_fail=1 and rsp_id=13, wbm_cycle never asserts. Requester 2 then frees id 12 -> wbm_write=1, wbm_writedata=12, rsp_fail=0.
- 14 consecutive allocs against a 13-buffer model -> the first 13 return distinct ids 0..12 with rsp_fail=0; the 14th gets readdata=all-ones and rsp_fail=1.
- Model never acks -> cycle/strobe stay high for exactly 16 cycles then drop, and rsp_fail=1, rsp_id=0. A separate run asserts reset during BUS -> cycle/strobe go 0 immediately and no rsp_valid follows.
